solitaire_shuffler: RTL and testbench
=====================================

# solitaire_shuffler

Generates a freshly shuffled 52-card deck and streams it card by card into the dealing logic, which fills the tableaus, talon and stock. It replaces the fixed deck file as the deck source. The block builds a sorted deck in internal storage and permutes it with a Fisher-Yates pass driven by a 16-bit LFSR. It then emits the cards in index order, 0..51, over a valid/ready handshake.

## Interface
- SEED, 16'hACE1, LFSR seed loaded on start; a value of 0 is replaced by 16'hACE1.
- DECK_SIZE, 52, card count; fixed at 52, other values unsupported.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new shuffle; honoured only in IDLE or DONE.
- busy  output  1  high in INIT, SHUFFLE, STREAM.
- card_valid  output  1  card_data/card_index valid.
- card_ready  input  1  consumer accepts the current card.
- card_data  output  7  card: [6:3] rank 1..13, [2:1] suit (0 heart, 1 club, 2 diamond, 3 spade), [0] visibility, always 0 (face down).
- card_index  output  6  deck position 0..51 of card_data.
- done  output  1  level; high in DONE until the next accepted start or rst.

## Operation
- Storage: deck array [0:51] of 7-bit entries; lfsr[15:0]; index counter i[5:0].
- IDLE: outputs idle. If start, then lfsr <= (SEED==0 ? 16'hACE1 : SEED), i <= 0, and the state goes to INIT.
- INIT: one entry per cycle, deck[i] <= {rank = i%13+1, suit = i/13, 1'b0}. At i==51, set i <= 51 and go to SHUFFLE.
- SHUFFLE: one step per cycle for i = 51 down to 1.
  - j = ((lfsr * (i+1)) >> 16)[5:0], giving j ≤ i.
  - Swap deck[i] and deck[j] in the same cycle; j==i leaves the deck unchanged.
  - lfsr advances after use: lfsr <= lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1.
  - After i==1, set i <= 0 and go to STREAM.
- STREAM:
  - card_valid=1, card_data=deck[i], card_index=i.
  - A handshake is card_valid&&card_ready; it increments i.
  - A handshake at i==51 moves the state to DONE.
- DONE: done=1, card_valid=0. A start here restarts at INIT (reseeds from SEED, so the sequence repeats).
- start in INIT/SHUFFLE/STREAM is ignored.
- card_ready outside STREAM is ignored.
- Arithmetic: 16x6 unsigned multiply, 22-bit product, bits [21:16] are j. No modulo is used.

## Timing
- Reset values: busy=0, card_valid=0, done=0, card_data=0, card_index=0, state IDLE, lfsr=SEED-or-default, i=0.
- rst has priority over all activity, including mid-INIT, mid-SHUFFLE or mid-STREAM. It returns the block to IDLE the next cycle. A partially streamed deck is abandoned with no further valid.
- Start accepted at edge T:
  - busy=1 from T+1.
  - INIT occupies cycles T+1..T+52.
  - SHUFFLE occupies cycles T+53..T+103.
  - card_valid rises at T+104.
- Minimum stream is 52 cycles with card_ready held high. The last handshake at edge E gives done=1 and busy=0 at E+1.
- Backpressure: while card_valid && !card_ready, card_data and card_index are held stable. card_valid never drops before a handshake.
- Outputs are registered; card_ready has no combinational path to card_valid.
- A start in the same cycle as the final handshake is ignored, because the block is not yet in DONE.

## Configuration
- SHUFFLER_SEED_PORT_EN defined:
  - Adds port seed_in, input, 16 bits, sampled on the accepted start edge in place of SEED.
  - A seed_in value of 0 is replaced by 16'hACE1.
- Not defined: no seed_in port; SEED is used.
- All other behaviour is identical in both builds.

## Test plan
- Reset: assert rst 3 cycles → busy=0, card_valid=0, done=0, card_data=0, card_index=0.
- Full deal: start at T with SEED=16'hACE1 and card_ready=1 → first card_valid at T+104 with card_index=0. Then 52 consecutive handshakes with indices 0..51, each of the 52 {rank 1..13, suit 0..3} cards exactly once, bit0=0, and all cards matching a software Fisher-Yates model using the same LFSR/j rule. done=1 one cycle after index 51.
- Determinism: a second start from DONE → a sequence identical to the first deal. SEED=0 → the same sequence as SEED=16'hACE1.
- Backpressure: toggle card_ready randomly, including holding it low for 10 cycles at index 25 → card_data and card_index stable while stalled, no lost or duplicated cards.
- Ignored start: pulse start at T+60 and at index 10 of the stream → no restart, and the sequence is unchanged versus the full-deal case.
- Mid-operation reset: rst during SHUFFLE and again at index 30 → IDLE the next cycle with all outputs at reset values. A following start produces the full-deal sequence from index 0.

Source files
------------

// File: rtl/solitaire_shuffler_if.sv
// Card-stream bus between the deck shuffler and the dealing logic.
//   start       request a fresh shuffled deck
//   busy        shuffler is initialising, shuffling or streaming
//   card_valid  card_data / card_index hold a card
//   card_ready  consumer takes the current card
//   card_data   {rank[3:0], suit[1:0], face_up}
//   card_index  deck position 0..51 of card_data
//   done        whole deck delivered; level until the next start
// The master modport is the shuffler side, slave is the dealing side.
`timescale 1ns/1ps
interface solitaire_shuffler_if;
  logic       start;
  logic       busy;
  logic       card_valid;
  logic       card_ready;
  logic [6:0] card_data;
  logic [5:0] card_index;
  logic       done;

  modport master (
    input  start, card_ready,
    output busy, card_valid, card_data, card_index, done
  );

  modport slave (
    output start, card_ready,
    input  busy, card_valid, card_data, card_index, done
  );
endinterface

// File: rtl/solitaire_shuffler.sv
// Shuffled-deck source for the dealing logic.
// Builds a sorted 52-card deck, permutes it with a Fisher-Yates pass driven
// by a 16-bit Galois LFSR, then streams cards 0..51 over valid/ready.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   seed_in  LFSR seed sampled on an accepted start (only when the macro
//            SHUFFLER_SEED_PORT_EN is defined; otherwise SEED is used)
//   bus      solitaire_shuffler_if.master card-stream bus
// A zero seed is replaced by 16'hACE1 so the LFSR never locks up.
`timescale 1ns/1ps
module solitaire_shuffler #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          DECK_SIZE = 52
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef SHUFFLER_SEED_PORT_EN
  input  logic [15:0]           seed_in,
`endif
  solitaire_shuffler_if.master  bus
);

  localparam logic [5:0]  LAST         = 6'(DECK_SIZE - 1);
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {IDLE, INIT, SHUFFLE, STREAM, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [6:0]  deck [0:DECK_SIZE-1];
  logic [15:0] lfsr;
  logic [5:0]  idx;
  logic [5:0]  j;
  logic [15:0] seed_src;
  logic        handshake;

  function automatic logic [15:0] fix_seed(input logic [15:0] s);
    return (s == 16'd0) ? DEFAULT_SEED : s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [6:0] sorted_card(input logic [5:0] k);
    logic [3:0] rank;
    logic [1:0] suit;
    rank = 4'(k % 6'd13) + 4'd1;
    suit = 2'(k / 6'd13);
    return {rank, suit, 1'b0};
  endfunction

`ifdef SHUFFLER_SEED_PORT_EN
  assign seed_src = seed_in;
`else
  assign seed_src = SEED;
`endif

  assign handshake = (state == STREAM) && bus.card_valid && bus.card_ready;

  // Scaled-LFSR pick: the top bits of lfsr*(i+1) land in 0..i without a modulo.
  always_comb begin
    j = 6'((22'(lfsr) * 22'(idx + 6'd1)) >> 16);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (bus.start) state_next = INIT;
      INIT:       if (idx == LAST) state_next = SHUFFLE;
      SHUFFLE:    if (idx == 6'd1) state_next = STREAM;
      STREAM:     if (handshake && (idx == LAST)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr           <= fix_seed(SEED);
      idx            <= 6'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.card_valid <= 1'b0;
      bus.card_data  <= 7'd0;
      bus.card_index <= 6'd0;
    end else begin
      bus.busy <= (state_next == INIT) || (state_next == SHUFFLE) ||
                  (state_next == STREAM);
      bus.done <= (state_next == DONE);
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            lfsr <= fix_seed(seed_src);
            idx  <= 6'd0;
          end
        end
        INIT: begin
          deck[idx] <= sorted_card(idx);
          if (idx != LAST) idx <= idx + 6'd1;
        end
        SHUFFLE: begin
          deck[idx] <= deck[j];
          deck[j]   <= deck[idx];
          lfsr      <= lfsr_step(lfsr);
          if (idx == 6'd1) begin
            idx            <= 6'd0;
            bus.card_valid <= 1'b1;
            bus.card_index <= 6'd0;
            // The final swap may rewrite deck[0] on this same edge, so the
            // first card is taken from the post-swap value.
            bus.card_data  <= (j == 6'd0) ? deck[1] : deck[0];
          end else begin
            idx <= idx - 6'd1;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (idx == LAST) begin
              idx            <= 6'd0;
              bus.card_valid <= 1'b0;
              bus.card_data  <= 7'd0;
              bus.card_index <= 6'd0;
            end else begin
              idx            <= idx + 6'd1;
              bus.card_index <= idx + 6'd1;
              bus.card_data  <= deck[idx + 6'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_solitaire_shuffler.sv
`timescale 1ns/1ps
module tb_solitaire_shuffler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  solitaire_shuffler_if bus ();
  solitaire_shuffler_if bus0 ();

  assign bus0.start      = bus.start;
  assign bus0.card_ready = bus.card_ready;

`ifdef SHUFFLER_SEED_PORT_EN
  solitaire_shuffler #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .seed_in(16'hACE1), .bus(bus));
  solitaire_shuffler #(.SEED(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .seed_in(16'h0000), .bus(bus0));
`else
  solitaire_shuffler #(.SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  solitaire_shuffler #(.SEED(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
`endif

  int vectors    = 0;
  int miscompares = 0;
  logic [6:0] exp_deck [52];
  logic [6:0] got [52];

  // Reference: sorted deck, then textbook Fisher-Yates with the LFSR pick rule.
  task automatic build_model();
    logic [15:0] l;
    int jj;
    logic [6:0] t;
    l = 16'hACE1;
    for (int k = 0; k < 52; k++)
      exp_deck[k] = 7'(((k % 13) + 1) * 8 + (k / 13) * 2);
    for (int i = 51; i >= 1; i--) begin
      jj = (int'(l) * (i + 1)) >>> 16;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[jj];
      exp_deck[jj] = t;
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_valid"}, 32'(bus.card_valid), 32'd0);
    check({tag, "_done"},  32'(bus.done), 32'd0);
    check({tag, "_data"},  32'(bus.card_data), 32'd0);
    check({tag, "_index"}, 32'(bus.card_index), 32'd0);
  endtask

  // Start at edge T; ends in cycle T+104 where the first card must be offered.
  task automatic start_deal(input bit pulse_mid);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'd1);
    for (int k = 1; k <= 102; k++) begin
      step();
      bus.start = (pulse_mid && k == 59) ? 1'b1 : 1'b0;
      if (k == 51) check("busy_init", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    check("valid_early", 32'(bus.card_valid), 32'd0);
    step();
    check("valid_rise", 32'(bus.card_valid), 32'd1);
  endtask

  // mode 0: ready held high; 1: random ready with a 10-cycle stall at 25;
  // 2: ready high plus ignored start pulses; 3: reset at index 30.
  task automatic stream(input int mode);
    int n;
    int cyc;
    int stall;
    bit rdy;
    bit pulsed;
    n = 0; cyc = 0; stall = 0; pulsed = 0;
    while (n < 52 && cyc < 2000) begin
      check("valid_hold", 32'(bus.card_valid), 32'd1);
      check("index", 32'(bus.card_index), 32'(n));
      check("card", 32'(bus.card_data), 32'(exp_deck[n]));
      check("seed0_card", 32'(bus0.card_data), 32'(exp_deck[n]));
      if (mode == 3 && n == 30) begin
        rst = 1'b1;
        step();
        check_idle("rst_stream");
        rst = 1'b0;
        repeat (3) begin
          step();
          check("abandoned", 32'(bus.card_valid), 32'd0);
        end
        return;
      end
      if (mode == 1) begin
        if (n == 25 && stall < 10) begin
          rdy = 1'b0;
          stall++;
        end else begin
          rdy = ($urandom_range(0, 2) != 0);
        end
      end else begin
        rdy = 1'b1;
      end
      bus.start = (mode == 2 && ((n == 10 && !pulsed) || n == 51)) ? 1'b1 : 1'b0;
      if (mode == 2 && n == 10) pulsed = 1'b1;
      bus.card_ready = rdy;
      got[n] = bus.card_data;
      step();
      bus.start = 1'b0;
      cyc++;
      if (rdy) n++;
    end
    bus.card_ready = 1'b1;
    check("stream_count", 32'(n), 32'd52);
    if (mode != 1) check("stream_len", 32'(cyc), 32'd52);
    check("done_rise", 32'(bus.done), 32'd1);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("valid_fall", 32'(bus.card_valid), 32'd0);
    step();
    check("done_level", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic check_unique();
    bit seen [128];
    int distinct;
    distinct = 0;
    for (int k = 0; k < 128; k++) seen[k] = 1'b0;
    for (int k = 0; k < 52; k++) begin
      if (!seen[got[k]] && got[k][0] == 1'b0 && got[k][6:3] >= 4'd1 &&
          got[k][6:3] <= 4'd13) begin
        seen[got[k]] = 1'b1;
        distinct++;
      end
    end
    check("unique_cards", 32'(distinct), 32'd52);
  endtask

  initial begin
    build_model();
    bus.start = 1'b0;
    bus.card_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check_idle("reset");
    rst = 1'b0;
    step();
    check_idle("idle");

    // Full deal, ready held high.
    bus.card_ready = 1'b1;
    start_deal(1'b0);
    stream(0);
    check_unique();

    // Restart from DONE repeats the sequence.
    start_deal(1'b0);
    stream(0);

    // Random backpressure.
    start_deal(1'b0);
    stream(1);
    check_unique();

    // Starts during SHUFFLE, STREAM and the final handshake are ignored.
    start_deal(1'b1);
    stream(2);

    // Reset during SHUFFLE.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (65) step();
    check("shuffle_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    check_idle("rst_shuffle");
    rst = 1'b0;
    step();
    check_idle("post_rst");
    start_deal(1'b0);
    stream(0);

    // Reset mid-stream, then a clean deal.
    start_deal(1'b0);
    stream(3);
    check_idle("after_abort");
    start_deal(1'b0);
    stream(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
